alu_datamem_seq: RTL and testbench
==================================

ALU_DATAMEM_SEQ -- requirements
Module: alu_datamem_seq

Interface
REQ-001 Parameter WIDTH, default 16, datapath/register/memory word width in bits.
REQ-002 Parameter NREG, default 8, register count (power of 2, >=2); RAW = clog2(NREG).
REQ-003 Parameter DEPTH, default 64, data-memory words (power of 2); MAW = clog2(DEPTH).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 op_valid  in  1  micro-op present on op fields.
REQ-007 op_ready  out  1  block idle and accepting a micro-op.
REQ-008 alu_op  in  4  ALU operation code (REQ-016).
REQ-009 alu_src1  in  1  0: operand A = reg[rd_addr1]; 1: operand A = 0.
REQ-010 alu_src2  in  1  0: operand B = reg[rd_addr2]; 1: operand B = imm.
REQ-011 imm  in  WIDTH  immediate operand.
REQ-012 rd_addr1, rd_addr2, wr_addr  in  RAW each  source/destination register addresses.
REQ-013 reg_write, mem_write, mem_to_reg  in  1 each  writeback enable, store enable, writeback source (0 ALU, 1 memory).
REQ-014 done  out  1  one-cycle completion pulse; result, ovf, take_branch, mem_err  out  WIDTH,1,1,1  registered status of last completed op, held until next done.

Function
REQ-015 FSM states IDLE, READ, EXEC, MEM, WB; op_ready=1 only in IDLE; handshake op_valid&&op_ready moves IDLE->READ and latches all op fields; READ->EXEC->MEM->WB->IDLE unconditionally, one edge each.
REQ-016 alu_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SLL, 7 SRL, 8 SRA (shift A by B[clog2(WIDTH)-1:0]), 9 SLT signed (1/0), 10 BEQ, 11 BNE, 12 BLT signed (result A-B), 13-15 result 0.
REQ-017 All arithmetic modulo 2^WIDTH; ovf=1 only for ADD/SUB signed overflow, else 0.
REQ-018 take_branch=1 only for BEQ (A==B), BNE (A!=B), BLT (A<B signed); 0 for all other ops.
REQ-019 READ captures operands (per REQ-009/010); EXEC registers ALU result and flags.
REQ-020 Register 0 reads as 0 always; writes to register 0 ignored.
REQ-021 MEM: address = ALU result; mem_err=1 if result >= DEPTH; else write reg[rd_addr2] to mem[result[MAW-1:0]] when mem_write=1; memory read asynchronous.
REQ-022 On mem_err: store suppressed, load data = 0.
REQ-023 WB: done=1 for exactly this one cycle; result = memory data if mem_to_reg else ALU result; register write at WB->IDLE edge if reg_write and wr_addr!=0.
REQ-024 Latency: done high in cycle after 4th edge following the accepting edge; next accept no earlier than the IDLE cycle after WB (max throughput 1 op per 5 cycles).
REQ-025 op_valid and field changes outside IDLE ignored; no hazards exist (strictly sequential).
REQ-026 Memory zero-initialised at configuration; not cleared by reset.

Reset
REQ-027 reset=0 at an edge: state IDLE, all registers 0, done/result/ovf/take_branch/mem_err 0; op_ready=0 while reset=0, 1 first cycle after release.
REQ-028 reset mid-operation aborts: no pending register or memory write occurs, including reset in MEM or WB.

Verification
REQ-029 Reset; ADD src1=1,src2=1,imm=0x0005,wr=r1 -> done 4 edges after accept, result=0x0005; then ADD r1+imm 0x7FFB -> result=0x8000, ovf=1.
REQ-030 Store: r3=0xBEEF, ADD zero+imm 0x0010, mem_write=1, rd2=r3; load ADD zero+imm 0x0010, mem_to_reg=1, wr=r4 -> result=0xBEEF, r4=0xBEEF.
REQ-031 DEPTH=64, store to address 0x0040 -> mem_err=1, memory unchanged; load from 0x0040 -> result=0x0000.
REQ-032 BEQ r1(0x0005) vs imm 0x0005, reg_write=1, wr=r0 -> take_branch=1, result=0x0000, r0 still reads 0; BLT 0x8000 vs 0x0001 -> take_branch=1.
REQ-033 Store 0x1234 to 0x0005, reset=0 while in MEM -> mem[5] unchanged, all regs 0, op_ready low during reset, high after.
REQ-034 op_valid held 1 for 20 cycles -> exactly 4 ops accepted, done pulses 5 cycles apart, never two consecutive done cycles.

Source files
------------

// File: rtl/alu_datamem_seq.sv
// Purpose : sequential micro-op engine: register file, ALU and data memory, one op at a time.
// Latency : done pulses in the fifth cycle of an op (IDLE accept -> READ -> EXEC -> MEM -> WB).
// Backpr. : op_ready high only in IDLE; op_valid and op fields are ignored while an op is in flight.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   op_valid/op_ready   micro-op handshake (accept on op_valid && op_ready)
//   alu_op, alu_src1/2  ALU function and operand selects; imm is the immediate operand
//   rd_addr1/2, wr_addr source and destination registers
//   reg_write, mem_write, mem_to_reg  writeback enable, store enable, writeback source
//   done                one-cycle completion pulse
//   result, ovf, take_branch, mem_err  status of the last completed op, held until the next done
module alu_datamem_seq #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int DEPTH = 64,
    localparam int RAW  = $clog2(NREG),
    localparam int MAW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       alu_op,
    input  logic             alu_src1,
    input  logic             alu_src2,
    input  logic [WIDTH-1:0] imm,
    input  logic [RAW-1:0]   rd_addr1,
    input  logic [RAW-1:0]   rd_addr2,
    input  logic [RAW-1:0]   wr_addr,
    input  logic             reg_write,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             take_branch,
    output logic             mem_err
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, READ, EXEC, MEM, WB} state_t;

    state_t state_q, state_d;
    logic   accept;

    // Latched micro-op fields
    logic [3:0]       alu_op_q;
    logic             src1_q, src2_q;
    logic [WIDTH-1:0] imm_q;
    logic [RAW-1:0]   rd1_q, rd2_q, wr_q;
    logic             reg_write_q, mem_write_q, mem_to_reg_q;

    // Pipeline-stage registers
    logic [WIDTH-1:0] opa_q, opb_q;
    logic [WIDTH-1:0] alu_q;
    logic             alu_ovf_q, alu_br_q;
    logic [WIDTH-1:0] result_q;
    logic             ovf_q, br_q, merr_q;

    logic [WIDTH-1:0] rf_q [NREG];
    // Memory contents survive reset; they start at zero from configuration.
    logic [WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        op_ready = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                op_ready = reset;
                if (op_valid && reset) state_d = READ;
            end
            READ: state_d = EXEC;
            EXEC: state_d = MEM;
            MEM:  state_d = WB;
            WB: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = op_valid && op_ready;

    // ------------------------------------------------------------------
    // Register-file reads (r0 is hard-wired to zero)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rs1_val, rs2_val;

    always_comb begin
        rs1_val = (rd1_q == '0) ? '0 : rf_q[rd1_q];
        rs2_val = (rd2_q == '0) ? '0 : rf_q[rd2_q];
    end

    // ------------------------------------------------------------------
    // ALU (evaluated during EXEC from the captured operands)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] alu_d, sum, diff;
    logic             alu_ovf_d, alu_br_d, lt_s;
    logic [SHW-1:0]   shamt;

    always_comb begin
        sum       = opa_q + opb_q;
        diff      = opa_q - opb_q;
        lt_s      = $signed(opa_q) < $signed(opb_q);
        shamt     = opb_q[SHW-1:0];
        alu_d     = '0;
        alu_ovf_d = 1'b0;
        alu_br_d  = 1'b0;
        case (alu_op_q)
            4'd0: begin
                alu_d     = sum;
                // Same-sign operands producing a different-sign sum
                alu_ovf_d = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (sum[WIDTH-1] != opa_q[WIDTH-1]);
            end
            4'd1: begin
                alu_d     = diff;
                alu_ovf_d = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) && (diff[WIDTH-1] != opa_q[WIDTH-1]);
            end
            4'd2:  alu_d = opa_q & opb_q;
            4'd3:  alu_d = opa_q | opb_q;
            4'd4:  alu_d = opa_q ^ opb_q;
            4'd5:  alu_d = ~opa_q;
            4'd6:  alu_d = opa_q << shamt;
            4'd7:  alu_d = opa_q >> shamt;
            4'd8:  alu_d = $unsigned($signed(opa_q) >>> shamt);
            4'd9:  alu_d = {{(WIDTH-1){1'b0}}, lt_s};
            // Branch compares report A-B as their result
            4'd10: begin alu_d = diff; alu_br_d = (opa_q == opb_q); end
            4'd11: begin alu_d = diff; alu_br_d = (opa_q != opb_q); end
            4'd12: begin alu_d = diff; alu_br_d = lt_s;             end
            default: alu_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory access (asynchronous read during MEM)
    // ------------------------------------------------------------------
    logic [MAW-1:0]   mem_addr;
    logic             mem_oob;
    logic [WIDTH-1:0] mem_rdat, wb_d;

    always_comb begin
        mem_addr = alu_q[MAW-1:0];
        // DEPTH is a power of two, so any set bit above the index is out of range
        mem_oob  = |alu_q[WIDTH-1:MAW];
        mem_rdat = mem_oob ? '0 : mem_q[mem_addr];
        wb_d     = mem_to_reg_q ? mem_rdat : alu_q;
    end

    // Store happens on the MEM->WB edge; a reset on that edge cancels it.
    always_ff @(posedge clk) begin
        if (reset && (state_q == MEM) && mem_write_q && !mem_oob)
            mem_q[mem_addr] <= rs2_val;
    end

    // ------------------------------------------------------------------
    // Datapath registers and register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_op_q     <= '0;
            src1_q       <= 1'b0;
            src2_q       <= 1'b0;
            imm_q        <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            wr_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            opa_q        <= '0;
            opb_q        <= '0;
            alu_q        <= '0;
            alu_ovf_q    <= 1'b0;
            alu_br_q     <= 1'b0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            br_q         <= 1'b0;
            merr_q       <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_op_q     <= alu_op;
                        src1_q       <= alu_src1;
                        src2_q       <= alu_src2;
                        imm_q        <= imm;
                        rd1_q        <= rd_addr1;
                        rd2_q        <= rd_addr2;
                        wr_q         <= wr_addr;
                        reg_write_q  <= reg_write;
                        mem_write_q  <= mem_write;
                        mem_to_reg_q <= mem_to_reg;
                    end
                end
                READ: begin
                    opa_q <= src1_q ? '0 : rs1_val;
                    opb_q <= src2_q ? imm_q : rs2_val;
                end
                EXEC: begin
                    alu_q     <= alu_d;
                    alu_ovf_q <= alu_ovf_d;
                    alu_br_q  <= alu_br_d;
                end
                MEM: begin
                    // Status is loaded here so it is already valid while done is high
                    result_q <= wb_d;
                    ovf_q    <= alu_ovf_q;
                    br_q     <= alu_br_q;
                    merr_q   <= mem_oob;
                end
                WB: begin
                    if (reg_write_q && (wr_q != '0)) rf_q[wr_q] <= result_q;
                end
                default: ;
            endcase
        end
    end

    assign result      = result_q;
    assign ovf         = ovf_q;
    assign take_branch = br_q;
    assign mem_err     = merr_q;

endmodule

// File: tb/tb_alu_datamem_seq.sv
// Purpose : self-checking bench for alu_datamem_seq against a behavioural model.
// Latency : checks done in the fifth cycle of each op and 5-cycle throughput.
// Backpr. : waits on op_ready with a bounded cycle budget.
module tb_alu_datamem_seq;

    localparam int W     = 16;
    localparam int NREG  = 8;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [3:0]    alu_op = '0;
    logic          alu_src1 = 1'b0, alu_src2 = 1'b0;
    logic [W-1:0]  imm = '0;
    logic [2:0]    rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0;
    logic          reg_write = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0;
    logic          done;
    logic [W-1:0]  result;
    logic          ovf, take_branch, mem_err;

    alu_datamem_seq #(.WIDTH(W), .NREG(NREG), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .imm(imm),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_addr(wr_addr),
        .reg_write(reg_write), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .done(done), .result(result), .ovf(ovf), .take_branch(take_branch), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic         s1, s2;
        logic [W-1:0] imm;
        logic [2:0]   rd1, rd2, wr;
        logic         rw, mw, m2r;
    } op_t;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_rf  [NREG];
    logic [W-1:0] m_mem [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic op_t mk(input logic [3:0] op, input logic s1, input logic [2:0] rd1,
                               input logic s2, input logic [W-1:0] im, input logic [2:0] rd2,
                               input logic [2:0] wr, input logic rw, input logic mw, input logic m2r);
        op_t o;
        o.op = op; o.s1 = s1; o.rd1 = rd1; o.s2 = s2; o.imm = im; o.rd2 = rd2;
        o.wr = wr; o.rw = rw; o.mw = mw; o.m2r = m2r;
        return o;
    endfunction

    // Behavioural reference: computes the op from the architectural rules with
    // plain integer arithmetic; optionally commits register/memory side effects.
    task automatic model(input op_t o, input bit commit, output logic [W-1:0] res,
                         output logic ov, output logic br, output logic me);
        logic [W-1:0] a, b, r, ld;
        int sa, sb, t;
        int sh;
        a  = o.s1 ? '0 : m_rf[o.rd1];
        b  = o.s2 ? o.imm : m_rf[o.rd2];
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = int'(b) % W;
        r = '0; ov = 1'b0; br = 1'b0;
        case (o.op)
            4'd0:  begin t = sa + sb; r = t[W-1:0]; ov = (t > 32767) || (t < -32768); end
            4'd1:  begin t = sa - sb; r = t[W-1:0]; ov = (t > 32767) || (t < -32768); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~a;
            4'd6:  r = a << sh;
            4'd7:  r = a >> sh;
            4'd8:  begin t = sa >>> sh; r = t[W-1:0]; end
            4'd9:  r = (sa < sb) ? 16'd1 : 16'd0;
            4'd10: begin r = a - b; br = (a == b); end
            4'd11: begin r = a - b; br = (a != b); end
            4'd12: begin r = a - b; br = (sa < sb); end
            default: r = '0;
        endcase
        me  = (int'(r) >= DEPTH);
        ld  = me ? '0 : m_mem[int'(r) % DEPTH];
        res = o.m2r ? ld : r;
        if (commit) begin
            if (o.mw && !me) m_mem[int'(r) % DEPTH] = m_rf[o.rd2];
            if (o.rw && o.wr != 3'd0) m_rf[o.wr] = res;
        end
    endtask

    task automatic drive(input op_t o);
        alu_op = o.op; alu_src1 = o.s1; alu_src2 = o.s2; imm = o.imm;
        rd_addr1 = o.rd1; rd_addr2 = o.rd2; wr_addr = o.wr;
        reg_write = o.rw; mem_write = o.mw; mem_to_reg = o.m2r;
    endtask

    task automatic scramble();
        alu_op = 4'($urandom); alu_src1 = 1'($urandom); alu_src2 = 1'($urandom);
        imm = 16'($urandom); rd_addr1 = 3'($urandom); rd_addr2 = 3'($urandom);
        wr_addr = 3'($urandom); reg_write = 1'($urandom); mem_write = 1'($urandom);
        mem_to_reg = 1'($urandom);
    endtask

    // Waits for op_ready, issues one op, checks latency and status, commits the model.
    // Starts near a falling edge and returns on a falling edge.
    task automatic run_op(input op_t o, input string tag);
        logic [W-1:0] er;
        logic eo, eb, em;
        int n, k;
        model(o, 1'b0, er, eo, eb, em);
        n = 0;
        while (!op_ready && n < 20) begin @(negedge clk); n++; end
        if (!op_ready) begin check({tag, "_ready_timeout"}, 0, 1); return; end
        drive(o);
        op_valid = 1'b1;
        @(negedge clk);
        // Op is in flight; changing the fields now must have no effect.
        op_valid = 1'b0;
        scramble();
        k = 0;
        while (!done && k < 8) begin @(negedge clk); k++; end
        check({tag, "_latency"}, k, 3);
        if (!done) return;
        check({tag, "_result"}, result, er);
        check({tag, "_ovf"}, ovf, eo);
        check({tag, "_branch"}, take_branch, eb);
        check({tag, "_memerr"}, mem_err, em);
        model(o, 1'b1, er, eo, eb, em);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        int acc, ndone, last_done, consec;
        logic [W-1:0] mem5_before;

        for (int i = 0; i < NREG; i++) m_rf[i] = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", op_ready, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_flags", {ovf, take_branch, mem_err}, 0);
        reset = 1'b1;
        #1;
        check("rst_release_ready", op_ready, 1);

        // Immediate load and signed overflow
        run_op(mk(4'd0, 1, 0, 1, 16'h0005, 0, 1, 1, 0, 0), "add_imm");
        check("add_imm_const", result, 16'h0005);
        run_op(mk(4'd0, 0, 1, 1, 16'h7FFB, 0, 0, 0, 0, 0), "add_ovf");
        check("add_ovf_const", {ovf, result}, {1'b1, 16'h8000});

        // Store then load
        run_op(mk(4'd0, 1, 0, 1, 16'hBEEF, 0, 3, 1, 0, 0), "set_r3");
        run_op(mk(4'd0, 1, 0, 1, 16'h0010, 3, 0, 0, 1, 0), "store");
        run_op(mk(4'd0, 1, 0, 1, 16'h0010, 0, 4, 1, 0, 1), "load");
        check("load_const", result, 16'hBEEF);
        run_op(mk(4'd0, 0, 4, 1, 16'h0000, 0, 0, 0, 0, 0), "read_r4");
        check("read_r4_const", result, 16'hBEEF);

        // Out-of-range address: store suppressed, load yields zero
        run_op(mk(4'd0, 1, 0, 1, 16'h0040, 3, 0, 0, 1, 0), "store_oob");
        check("store_oob_err", mem_err, 1);
        run_op(mk(4'd0, 1, 0, 1, 16'h0040, 0, 0, 0, 0, 1), "load_oob");
        check("load_oob_const", {mem_err, result}, {1'b1, 16'h0000});
        run_op(mk(4'd0, 1, 0, 1, 16'h0000, 0, 0, 0, 0, 1), "load_m0");
        check("load_m0_const", result, 16'h0000);

        // Branches and r0 write protection
        run_op(mk(4'd10, 0, 1, 1, 16'h0005, 0, 0, 1, 0, 0), "beq");
        check("beq_const", {take_branch, result}, {1'b1, 16'h0000});
        run_op(mk(4'd0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0), "read_r0");
        check("read_r0_const", result, 16'h0000);
        run_op(mk(4'd0, 1, 0, 1, 16'h8000, 0, 5, 1, 0, 0), "set_r5");
        run_op(mk(4'd12, 0, 5, 1, 16'h0001, 0, 0, 0, 0, 0), "blt");
        check("blt_const", take_branch, 1);

        // Randomized ops against the model
        for (int i = 0; i < 80; i++) begin
            o.op  = 4'($urandom_range(0, 15));
            o.s1  = 1'($urandom_range(0, 3) == 0);
            o.s2  = 1'($urandom);
            o.imm = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 80)) : 16'($urandom);
            o.rd1 = 3'($urandom); o.rd2 = 3'($urandom); o.wr = 3'($urandom);
            o.rw  = 1'($urandom); o.mw = 1'($urandom_range(0, 3) == 0);
            o.m2r = 1'($urandom_range(0, 3) == 0);
            run_op(o, $sformatf("rnd%0d", i));
        end

        // Reset during MEM aborts the pending store and clears registers
        run_op(mk(4'd0, 1, 0, 1, 16'h1234, 0, 2, 1, 0, 0), "set_r2");
        mem5_before = m_mem[5];
        drive(mk(4'd0, 1, 0, 1, 16'h0005, 2, 0, 0, 1, 0));
        op_valid = 1'b1;
        @(negedge clk);             // READ
        op_valid = 1'b0;
        @(negedge clk);             // EXEC
        @(negedge clk);             // MEM
        reset = 1'b0;
        #1;
        check("midrst_ready_low", op_ready, 0);
        @(negedge clk);
        check("midrst_ready_low2", op_ready, 0);
        check("midrst_done", done, 0);
        check("midrst_status", {result, ovf, take_branch, mem_err}, 0);
        reset = 1'b1;
        #1;
        check("midrst_ready_high", op_ready, 1);
        for (int i = 0; i < NREG; i++) m_rf[i] = '0;
        run_op(mk(4'd0, 1, 0, 1, 16'h0005, 0, 0, 0, 0, 1), "midrst_load");
        check("midrst_mem5", result, mem5_before);
        for (int i = 1; i < NREG; i++) begin
            run_op(mk(4'd0, 0, 3'(i), 1, 16'h0000, 0, 0, 0, 0, 0), $sformatf("midrst_r%0d", i));
            check($sformatf("midrst_r%0d_zero", i), result, 0);
        end

        // Throughput: op_valid held for 20 cycles
        run_op(mk(4'd0, 1, 0, 1, 16'h0000, 0, 1, 1, 0, 0), "clr_r1");
        drive(mk(4'd0, 0, 1, 1, 16'h0001, 0, 1, 1, 0, 0));
        acc = 0; ndone = 0; last_done = -10; consec = 0;
        for (int i = 0; i < 28; i++) begin
            op_valid = (i < 20);
            #1;
            if (op_valid && op_ready) acc++;
            if (done) begin
                if (last_done == i - 1) consec++;
                if (ndone > 0) check($sformatf("tput_gap%0d", ndone), i - last_done, 5);
                last_done = i;
                ndone++;
            end
            @(negedge clk);
        end
        check("tput_accepts", acc, 4);
        check("tput_dones", ndone, 4);
        check("tput_consecutive", consec, 0);
        o = mk(4'd0, 0, 1, 1, 16'h0001, 0, 1, 1, 0, 0);
        begin
            logic [W-1:0] r; logic a1, a2, a3;
            for (int i = 0; i < 4; i++) model(o, 1'b1, r, a1, a2, a3);
        end
        run_op(mk(4'd0, 0, 1, 1, 16'h0000, 0, 0, 0, 0, 0), "tput_r1");
        check("tput_r1_const", result, 16'h0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
